register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter: WIDTH, default 32, data width of the stored word and of both data ports.
REQ-002 Parameter: RESET_VALUE, default 0 (WIDTH bits), value loaded into storage on reset.
REQ-003 Port: clk  input  1  clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: oe  input  1  output enable; when high, the stored word is presented on out.
REQ-006 Port: we  input  1  write enable; when high at a clk rising edge, in is captured.
REQ-007 Port: in  input  WIDTH  write data.
REQ-008 Port: out  output  WIDTH  read data, gated by oe.
REQ-009 Port order SHALL be clk, rst, oe, we, in, out, so positional instantiation works.

Function
REQ-010 Storage SHALL be one WIDTH-bit register, value Q.
REQ-011 At a rising clk edge with rst low and we high, Q SHALL take the value of in; latency is 1 cycle.
REQ-012 At a rising clk edge with we low, Q SHALL hold its value.
REQ-013 out SHALL be combinational: out = Q when oe is high, all-zero when oe is low.
REQ-014 out SHALL never be high-impedance; a zero default lets several registers share a bus through OR logic.
REQ-015 When we and oe are both high in the same cycle, out SHALL show the old Q until the edge and the new Q after it; there is no write-through from in to out.
REQ-016 X or Z on in while we is low SHALL NOT affect Q.
REQ-017 Back-to-back writes on consecutive edges SHALL each take effect; the last write wins.
REQ-018 The block SHALL have no other state, no FSM, and no handshake; every cycle with we high is a write.

Reset
REQ-019 rst high SHALL force Q to RESET_VALUE immediately, without waiting for a clock edge.
REQ-020 While rst is high, Q SHALL hold RESET_VALUE and writes SHALL be ignored, even if we is high.
REQ-021 During reset, out SHALL equal RESET_VALUE if oe is high, and 0 if oe is low.
REQ-022 Reset asserted between edges, mid-operation, SHALL discard any pending write.
REQ-023 After rst deasserts, the first write SHALL occur at the next rising edge with we high.

Structure
REQ-024 The shared package SHALL hold the default data-width constant (32) and the default reset value (0); there are no typedefs.
REQ-025 The block SHALL be a single module with no sub-modules.
REQ-026 Synthesis SHALL yield WIDTH flip-flops with asynchronous reset, an enable mux, and an AND gate on the output.

Verification
REQ-027 Reset check: pulse rst with oe=1 -> out=0x00000000 with no clock edge needed; with oe=0 -> out=0.
REQ-028 Write/read check: we=1, in=0xDEADBEEF, one edge, then we=0, oe=1 -> out=0xDEADBEEF; with oe=0 -> out=0.
REQ-029 Hold check: after writing 0x12345678, drive we=0, in=0xFFFFFFFF for 5 edges -> out stays 0x12345678.
REQ-030 Write-while-read check: Q=0x1, oe=1, we=1, in=0x2 -> out=0x1 before the edge and 0x2 after it.
REQ-031 Async reset check: Q=0xA5A5A5A5, rst raised between edges while we=1, in=0x5 -> out=0 at once and stays 0 through the next edge.
REQ-032 Width check: WIDTH=8, RESET_VALUE=0x3C -> after reset out=0x3C with oe=1; write 0xFF -> out=0xFF.

Source files
------------

// File: rtl/register_pkg.sv
// Shared defaults for the storage register: data width and reset value.
package register_pkg;

  localparam int unsigned      DEFAULT_WIDTH       = 32;
  localparam logic [31:0]      DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/register.sv
// Single-word storage register with write enable, async reset and an
// AND-gated read port that drives zero when not enabled (OR-bus friendly).
module register
  import register_pkg::*;
#(
  parameter int unsigned          WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe,
  input  logic             we,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // The mux keeps `in` out of the path entirely while we is low.
  always_comb begin
    data_d = data_q;
    if (we) data_d = in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= RESET_VALUE;
    else     data_q <= data_d;
  end

  assign out = data_q & {WIDTH{oe}};

endmodule

// File: tb/tb_register.sv
// Scoreboard bench: stimulus pushes expected read values, a monitor pops
// and compares them against the live DUT outputs.
module tb_register;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        oe  = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] in32 = '0;
  logic [7:0]  in8  = '0;
  logic [31:0] out32;
  logic [7:0]  out8;

  always #5 clk = ~clk;

  register dut32 (
    .clk (clk), .rst (rst), .oe (oe), .we (we), .in (in32), .out (out32)
  );

  register #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
    .clk (clk), .rst (rst), .oe (oe), .we (we), .in (in8), .out (out8)
  );

  typedef struct {
    string       name;
    bit          narrow;
    logic [31:0] exp;
  } exp_t;

  exp_t queue_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   sample_tgl = 1'b0;

  // Monitor: on each sample request, drain the scoreboard against the outputs.
  initial begin
    forever begin
      @(sample_tgl);
      while (queue_q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e   = queue_q.pop_front();
        act = e.narrow ? {24'h0, out8} : out32;
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input bit narrow, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.narrow = narrow; e.exp = exp;
    queue_q.push_back(e);
  endtask

  task automatic sample();
    sample_tgl = ~sample_tgl;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Async reset, no clock edge yet (first posedge at t=5)
    #1 rst = 1'b1; oe = 1'b1;
    #1;
    expect_out("reset_oe1", 0, 32'h0);
    expect_out("reset_oe1_w8", 1, 32'h3C);
    sample();
    oe = 1'b0; #1;
    expect_out("reset_oe0", 0, 32'h0);
    expect_out("reset_oe0_w8", 1, 32'h0);
    sample();

    // Writes ignored while reset is held
    we = 1'b1; in32 = 32'h1111_1111; in8 = 8'h11; oe = 1'b1;
    @(posedge clk); #1;
    expect_out("reset_ignores_write", 0, 32'h0);
    expect_out("reset_ignores_write_w8", 1, 32'h3C);
    sample();

    // Release reset, write DEADBEEF / FF
    @(negedge clk);
    rst = 1'b0; we = 1'b1; in32 = 32'hDEAD_BEEF; in8 = 8'hFF;
    @(negedge clk);
    we = 1'b0; oe = 1'b1; #1;
    expect_out("write_read", 0, 32'hDEAD_BEEF);
    expect_out("write_read_w8", 1, 32'hFF);
    sample();
    oe = 1'b0; #1;
    expect_out("write_oe0", 0, 32'h0);
    sample();

    // Hold for 5 edges with garbage on in
    @(negedge clk);
    we = 1'b1; in32 = 32'h1234_5678; oe = 1'b1;
    @(negedge clk);
    we = 1'b0; in32 = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_out($sformatf("hold_%0d", i), 0, 32'h1234_5678);
      sample();
    end

    // Unknown data on in with we low
    in32 = 'x; in8 = 'x;
    @(negedge clk);
    expect_out("x_in_we0", 0, 32'h1234_5678);
    expect_out("x_in_we0_w8", 1, 32'hFF);
    sample();

    // Write-while-read: old value before the edge, new after it
    we = 1'b1; in32 = 32'h1; in8 = 8'h00;
    @(negedge clk);
    in32 = 32'h2; #1;
    expect_out("wwr_before", 0, 32'h1);
    sample();
    @(posedge clk); #1;
    expect_out("wwr_after", 0, 32'h2);
    sample();

    // Back-to-back writes, last wins
    @(negedge clk);
    in32 = 32'hAA; in8 = 8'h0A;
    @(negedge clk);
    expect_out("b2b_1", 0, 32'hAA);
    sample();
    in32 = 32'hBB; in8 = 8'h0B;
    @(negedge clk);
    expect_out("b2b_2", 0, 32'hBB);
    sample();
    in32 = 32'hCC; in8 = 8'h0C;
    @(negedge clk);
    we = 1'b0;
    expect_out("b2b_last", 0, 32'hCC);
    expect_out("b2b_last_w8", 1, 32'h0C);
    sample();

    // Async reset mid-cycle discards a pending write
    we = 1'b1; in32 = 32'hA5A5_A5A5;
    @(negedge clk);
    in32 = 32'h5; in8 = 8'h05;
    #2 rst = 1'b1; #1;
    expect_out("async_rst_now", 0, 32'h0);
    expect_out("async_rst_now_w8", 1, 32'h3C);
    sample();
    @(posedge clk); #1;
    expect_out("async_rst_edge", 0, 32'h0);
    expect_out("async_rst_edge_w8", 1, 32'h3C);
    sample();

    // First write after reset release
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    @(negedge clk);
    expect_out("post_rst_idle", 0, 32'h0);
    sample();
    we = 1'b1; in32 = 32'h77; in8 = 8'hFF;
    @(posedge clk); #1;
    we = 1'b0;
    expect_out("post_rst_write", 0, 32'h77);
    expect_out("post_rst_write_w8", 1, 32'hFF);
    sample();

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 100 && queue_q.size() > 0; i++) #1;
    if (queue_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", queue_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
